// File: rtl/arb_fsm_param.sv
// arb_fsm_param: N-requester grant arbiter with a registered one-hot grant.
//
// Parameters:
//   N        number of requesting agents (2..32)
//   IDW      width of gnt_id
//   MAX_HOLD maximum consecutive grant cycles per ownership (0 = no limit)
//   HCW      hold counter width (MAX_HOLD < 2**HCW)
//
// Ports:
//   clock    system clock, rising edge
//   reset    synchronous active-high reset
//   req      per-agent request, bit k = agent k
//   rr_mode  0 = fixed priority (lowest index), 1 = round robin; used in IDLE only
//   gnt      registered one-hot grant, zero when no owner
//   gnt_id   current owner index; keeps the last owner while idle
//   busy     high while any gnt bit is high
//   timeout  one-cycle pulse on the edge a forced release occurs
module arb_fsm_param #(
  parameter int N        = 4,
  parameter int IDW      = (N > 1) ? $clog2(N) : 1,
  parameter int MAX_HOLD = 0,
  parameter int HCW      = 16
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic           rr_mode,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           busy,
  output logic           timeout
);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [N-1:0]   r_gnt, w_gnt_nxt;
  logic [IDW-1:0] r_id, w_id_nxt;
  logic [IDW-1:0] r_last, w_last_nxt;
  logic [HCW-1:0] r_hold, w_hold_nxt;
  logic           r_to, w_to_nxt;

  logic [IDW-1:0] w_start;
  logic [2*N-1:0] w_req2;
  logic [2*N-1:0] w_shift;
  logic [N-1:0]   w_rot;
  logic [IDW-1:0] w_off;
  logic           w_found;
  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_win;
  logic [N-1:0]   w_win_oh;
  logic           w_owner_req;
  logic           w_others;
  logic           w_at_limit;

  // Winner search: rotate the request vector so the scan start lands at bit 0
  // (start is 0 in fixed mode, last+1 in round-robin mode), take the lowest
  // set bit, then add the start back modulo N.
  always_comb begin
    w_start = '0;
    if (rr_mode) begin
      w_start = (r_last == IDW'(N - 1)) ? '0 : r_last + 1'b1;
    end
    w_req2  = {req, req};
    w_shift = w_req2 >> w_start;
    w_rot   = w_shift[N-1:0];
    w_off   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_found && w_rot[i]) begin
        w_found = 1'b1;
        w_off   = IDW'(i);
      end
    end
    w_sum = {1'b0, w_start} + {1'b0, w_off};
    if (w_sum >= (IDW + 1)'(N)) begin
      w_sum = w_sum - (IDW + 1)'(N);
    end
    w_win    = w_sum[IDW-1:0];
    w_win_oh = N'(1) << w_win;
  end

  assign w_owner_req = |(req & r_gnt);
  assign w_others    = |(req & ~r_gnt);
  assign w_at_limit  = (MAX_HOLD != 0) && (r_hold == HCW'(MAX_HOLD));

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold;
    w_to_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = '0;
        if (|req) begin
          w_state_nxt = S_GRANT;
          w_gnt_nxt   = w_win_oh;
          w_id_nxt    = w_win;
          w_last_nxt  = w_win;
          w_hold_nxt  = HCW'(1);
        end
      end
      S_GRANT: begin
        // Owner release outranks the timeout when both happen on one edge.
        if (!w_owner_req) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
        end else if (w_at_limit && w_others) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = '0;
          w_to_nxt    = 1'b1;
        end else if (r_hold < HCW'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_id    <= '0;
      r_last  <= IDW'(N - 1);
      r_hold  <= '0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_id    <= w_id_nxt;
      r_last  <= w_last_nxt;
      r_hold  <= w_hold_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_id;
  assign busy    = |r_gnt;
  assign timeout = r_to;

endmodule

// File: tb/tb_arb_fsm_param.sv
// Bench for arb_fsm_param with N=4, MAX_HOLD=3. Each step drives one cycle of
// inputs, queues the outputs expected after the next rising edge, and checks
// them #1 after that edge.
module tb_arb_fsm_param;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       rr_mode;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    logic       rst;
    logic       rr;
    logic [3:0] rq;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       t;
  } vec_t;

  typedef struct {
    string      tag;
    logic [3:0] g;
    logic [1:0] id;
    logic       b;
    logic       t;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  arb_fsm_param #(
    .N        (4),
    .MAX_HOLD (3)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .rr_mode (rr_mode),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input string tag, input logic rst, input logic rr,
                      input logic [3:0] rq, input logic [3:0] g,
                      input logic [1:0] id, input logic b, input logic t);
    exp_t e;
    reset   = rst;
    rr_mode = rr;
    req     = rq;
    sb.push_back('{tag, g, id, b, t});
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({e.tag, " gnt"},     int'(gnt),     int'(e.g));
      chk({e.tag, " gnt_id"},  int'(gnt_id),  int'(e.id));
      chk({e.tag, " busy"},    int'(busy),    int'(e.b));
      chk({e.tag, " timeout"}, int'(timeout), int'(e.t));
    end
  endtask

  function automatic vec_t mk(input string tag, input logic rst, input logic rr,
                              input logic [3:0] rq, input logic [3:0] g,
                              input logic [1:0] id, input logic b, input logic t);
    vec_t v;
    v.tag = tag; v.rst = rst; v.rr = rr; v.rq = rq;
    v.g = g; v.id = id; v.b = b; v.t = t;
    return v;
  endfunction

  initial begin
    reset   = 1'b1;
    rr_mode = 1'b0;
    req     = 4'b0000;

    // reset and idle
    tbl.push_back(mk("rst0",  1, 0, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk("rst1",  1, 0, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk("idle0", 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk("idle1", 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    // fixed priority
    tbl.push_back(mk("fx_g1",   0, 0, 4'b1010, 4'b0010, 1, 1, 0));
    tbl.push_back(mk("fx_rel1", 0, 0, 4'b1000, 4'b0000, 1, 0, 0));
    tbl.push_back(mk("fx_g3",   0, 0, 4'b1000, 4'b1000, 3, 1, 0));
    tbl.push_back(mk("fx_rel3", 0, 0, 4'b0000, 4'b0000, 3, 0, 0));
    tbl.push_back(mk("fx_g2",   0, 0, 4'b1100, 4'b0100, 2, 1, 0));
    tbl.push_back(mk("fx_rel2", 0, 0, 4'b0000, 4'b0000, 2, 0, 0));
    tbl.push_back(mk("fx_g0",   0, 0, 4'b1001, 4'b0001, 0, 1, 0));
    tbl.push_back(mk("fx_rel0", 0, 0, 4'b0000, 4'b0000, 0, 0, 0));
    // round robin over 1111, two grant cycles each, one idle cycle between
    tbl.push_back(mk("rr_rst",  1, 1, 4'b0000, 4'b0000, 0, 0, 0));
    tbl.push_back(mk("rr_a0",   0, 1, 4'b1111, 4'b0001, 0, 1, 0));
    tbl.push_back(mk("rr_b0",   0, 1, 4'b1111, 4'b0001, 0, 1, 0));
    tbl.push_back(mk("rr_i0",   0, 1, 4'b1110, 4'b0000, 0, 0, 0));
    tbl.push_back(mk("rr_a1",   0, 1, 4'b1111, 4'b0010, 1, 1, 0));
    tbl.push_back(mk("rr_b1",   0, 1, 4'b1111, 4'b0010, 1, 1, 0));
    tbl.push_back(mk("rr_i1",   0, 1, 4'b1101, 4'b0000, 1, 0, 0));
    tbl.push_back(mk("rr_a2",   0, 1, 4'b1111, 4'b0100, 2, 1, 0));
    tbl.push_back(mk("rr_b2",   0, 1, 4'b1111, 4'b0100, 2, 1, 0));
    tbl.push_back(mk("rr_i2",   0, 1, 4'b1011, 4'b0000, 2, 0, 0));
    tbl.push_back(mk("rr_a3",   0, 1, 4'b1111, 4'b1000, 3, 1, 0));
    tbl.push_back(mk("rr_b3",   0, 1, 4'b1111, 4'b1000, 3, 1, 0));
    tbl.push_back(mk("rr_i3",   0, 1, 4'b0111, 4'b0000, 3, 0, 0));
    tbl.push_back(mk("rr_a0w",  0, 1, 4'b1111, 4'b0001, 0, 1, 0));
    tbl.push_back(mk("rr_b0w",  0, 1, 4'b1111, 4'b0001, 0, 1, 0));
    tbl.push_back(mk("rr_end",  0, 1, 4'b0000, 4'b0000, 0, 0, 0));
    // forced release after MAX_HOLD=3 cycles with agent 2 waiting
    tbl.push_back(mk("to_h1",   0, 1, 4'b0001, 4'b0001, 0, 1, 0));
    tbl.push_back(mk("to_h2",   0, 1, 4'b0101, 4'b0001, 0, 1, 0));
    tbl.push_back(mk("to_h3",   0, 1, 4'b0101, 4'b0001, 0, 1, 0));
    tbl.push_back(mk("to_rel",  0, 1, 4'b0101, 4'b0000, 0, 0, 1));
    tbl.push_back(mk("to_g2",   0, 1, 4'b0101, 4'b0100, 2, 1, 0));
    tbl.push_back(mk("to_end",  0, 1, 4'b0000, 4'b0000, 2, 0, 0));

    foreach (tbl[i]) begin
      step(tbl[i].tag, tbl[i].rst, tbl[i].rr, tbl[i].rq,
           tbl[i].g, tbl[i].id, tbl[i].b, tbl[i].t);
    end

    // lone requester keeps the grant well past MAX_HOLD, no timeout
    for (int k = 0; k < 12; k++) begin
      step("lone", 0, 1, 4'b0001, 4'b0001, 0, 1, 0);
    end
    step("lone_end", 0, 1, 4'b0000, 4'b0000, 0, 0, 0);

    // owner drops on the edge where the hold limit is reached: plain release
    step("sim_g1",   0, 1, 4'b0011, 4'b0010, 1, 1, 0);
    step("sim_h2",   0, 1, 4'b0011, 4'b0010, 1, 1, 0);
    step("sim_h3",   0, 1, 4'b0011, 4'b0010, 1, 1, 0);
    step("sim_rel",  0, 1, 4'b0001, 4'b0000, 1, 0, 0);
    step("sim_g0",   0, 1, 4'b0001, 4'b0001, 0, 1, 0);
    step("sim_end",  0, 1, 4'b0000, 4'b0000, 0, 0, 0);

    // rr_mode toggled mid-grant leaves the owner alone, applies at next IDLE
    step("mode_fx",  0, 0, 4'b0101, 4'b0001, 0, 1, 0);
    step("mode_tog", 0, 1, 4'b0101, 4'b0001, 0, 1, 0);
    step("mode_rel", 0, 1, 4'b0100, 4'b0000, 0, 0, 0);
    step("mode_rr",  0, 1, 4'b0101, 4'b0100, 2, 1, 0);

    // reset mid-grant, then agent 0 first under round robin
    step("mr_rst",   1, 1, 4'b1111, 4'b0000, 0, 0, 0);
    step("mr_g0",    0, 1, 4'b1111, 4'b0001, 0, 1, 0);
    step("mr_end",   0, 1, 4'b0000, 4'b0000, 0, 0, 0);

    chk("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
